// File: rtl/fifo_bypass_param.sv
// First-word-fall-through FIFO with occupancy count and almost-full flag, any DEPTH >= 1.
// Define FIFO_BYPASS_EN to let data pass combinationally from i to o when the FIFO is empty.
module fifo_bypass_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enq,
  input  logic [WIDTH-1:0]           i,
  output logic                       full_n,
  input  logic                       deq,
  output logic [WIDTH-1:0]           o,
  output logic                       empty_n,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             cnt_zero;
  logic             enq_ok;
  logic             deq_ok;
  logic             wr;
  logic             rd;

  // Handshake: a transfer happens on a rising edge where the request (enq/deq)
  // and its permission (full_n/empty_n) are both high; otherwise nothing moves.
  assign cnt_zero = (count == '0);
  assign full_n   = reset_n & (count != FULL_CNT);
  assign enq_ok   = enq & full_n;
  assign deq_ok   = deq & empty_n;
  assign rd       = deq_ok & ~cnt_zero;

`ifdef FIFO_BYPASS_EN
  assign empty_n = reset_n & (~cnt_zero | enq);
  assign o       = cnt_zero ? i : mem[head];
  // An empty FIFO with enq and deq together hands the word straight through.
  assign wr      = enq_ok & ~(cnt_zero & deq_ok);
`else
  assign empty_n = reset_n & ~cnt_zero;
  assign o       = mem[head];
  assign wr      = enq_ok;
`endif

  assign almost_full = (count >= AF_CNT);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (wr) tail <= ptr_inc(tail);
      if (rd) head <= ptr_inc(head);
      if (wr && !rd)      count <= count + CNT_ONE;
      else if (rd && !wr) count <= count - CNT_ONE;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr) mem[tail] <= i;
  end

endmodule
